// File: rtl/risc16_mem_pkg.sv
// Shared types and constants for the RISC16 memory responder and its boot loader.
// Optional checksum stage is enabled by defining RISC16_MEM_CHKSUM_EN.
package risc16_mem_pkg;

  localparam int DEPTH_WORDS_DEF = 4096;

  // Big-endian byte lanes: write-enable bit 0 covers [15:8], bit 1 covers [7:0]
  localparam int LANE_HI = 0;
  localparam int LANE_LO = 1;

  typedef enum logic [2:0] {
    CNT_HI = 3'd0,
    CNT_LO = 3'd1,
    DAT_HI = 3'd2,
    DAT_LO = 3'd3,
`ifdef RISC16_MEM_CHKSUM_EN
    CHK    = 3'd4,
`endif
    DONE   = 3'd5,
    ERR    = 3'd6
  } ld_state_e;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    sum8 = acc + b;
  endfunction

endpackage

// File: rtl/risc16_mem_array.sv
// Word-organised byte-lane memory: two combinational read ports, one lane-masked write port.
// Indices at or beyond DEPTH_WORDS read as zero and are never written.
module risc16_mem_array
  import risc16_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic [14:0] ra_idx,
  output logic [15:0] ra_data,
  input  logic [14:0] rb_idx,
  output logic [15:0] rb_data,
  input  logic [1:0]  we,
  input  logic [14:0] w_idx,
  input  logic [15:0] w_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [7:0] mem_hi_r [DEPTH_WORDS];
  logic [7:0] mem_lo_r [DEPTH_WORDS];

  function automatic logic in_range(input logic [14:0] idx);
    in_range = ({1'b0, idx} < 16'(DEPTH_WORDS));
  endfunction

  assign ra_data = in_range(ra_idx) ? {mem_hi_r[ra_idx[AW-1:0]], mem_lo_r[ra_idx[AW-1:0]]} : 16'h0000;
  assign rb_data = in_range(rb_idx) ? {mem_hi_r[rb_idx[AW-1:0]], mem_lo_r[rb_idx[AW-1:0]]} : 16'h0000;

  // Lane-masked write; storage is deliberately never cleared
  always_ff @(posedge clk) begin
    if (in_range(w_idx)) begin
      if (we[LANE_HI]) mem_hi_r[w_idx[AW-1:0]] <= w_data[15:8];
      if (we[LANE_LO]) mem_lo_r[w_idx[AW-1:0]] <= w_data[7:0];
    end
  end

endmodule

// File: rtl/risc16_mem_responder.sv
// Unified instruction/data memory for the RISC16 core with a byte-stream boot loader
// that holds the core in reset until an image is loaded. Define RISC16_MEM_CHKSUM_EN for the checksum byte.
module risc16_mem_responder
  import risc16_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        i_oe,
  output logic [15:0] i_din,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  output logic [15:0] d_din,
  input  logic [15:0] d_dout,
  input  logic [1:0]  d_we,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_data,
  input  logic        ld_restart,
  output logic        cpu_hold,
  output logic        ld_done,
  output logic        ld_err
);

  ld_state_e   state_r, state_next_s;
  logic [15:0] count_r, count_next_s, new_count_s;
  logic [14:0] word_cnt_r, word_cnt_next_s;
  logic [7:0]  hi_byte_r, hi_byte_next_s;
  logic        cpu_hold_r, ld_done_r, ld_err_r, ld_ready_r;
  logic        accept_s, last_word_s;
  logic [1:0]  mem_we_s;
  logic [14:0] mem_widx_s;
  logic [15:0] mem_wdata_s, ra_data_s, rb_data_s;
  logic        unused_addr_s;
`ifdef RISC16_MEM_CHKSUM_EN
  logic [7:0]  sum_r, sum_next_s;
`endif

  assign accept_s      = ld_valid & ld_ready_r;
  assign new_count_s   = {count_r[15:8], ld_data};
  assign last_word_s   = (({1'b0, word_cnt_r} + 16'd1) == count_r);
  assign unused_addr_s = i_addr[0] ^ d_addr[0];

  // Loader next-state and datapath updates
  always_comb begin
    state_next_s    = state_r;
    count_next_s    = count_r;
    word_cnt_next_s = word_cnt_r;
    hi_byte_next_s  = hi_byte_r;
`ifdef RISC16_MEM_CHKSUM_EN
    if (accept_s) sum_next_s = sum8(sum_r, ld_data);
    else          sum_next_s = sum_r;
`endif
    case (state_r)
      CNT_HI: begin
        if (accept_s) begin
          count_next_s = {ld_data, count_r[7:0]};
          state_next_s = CNT_LO;
        end else begin
          state_next_s = CNT_HI;
        end
      end
      CNT_LO: begin
        if (accept_s) begin
          count_next_s    = new_count_s;
          word_cnt_next_s = 15'd0;
          if (new_count_s == 16'd0) begin
`ifdef RISC16_MEM_CHKSUM_EN
            state_next_s = CHK;
`else
            state_next_s = DONE;
`endif
          end else if ({1'b0, new_count_s} > 17'(DEPTH_WORDS)) begin
            state_next_s = ERR;
          end else begin
            state_next_s = DAT_HI;
          end
        end else begin
          state_next_s = CNT_LO;
        end
      end
      DAT_HI: begin
        if (accept_s) begin
          hi_byte_next_s = ld_data;
          state_next_s   = DAT_LO;
        end else begin
          state_next_s = DAT_HI;
        end
      end
      DAT_LO: begin
        if (accept_s) begin
          word_cnt_next_s = word_cnt_r + 15'd1;
          if (last_word_s) begin
`ifdef RISC16_MEM_CHKSUM_EN
            state_next_s = CHK;
`else
            state_next_s = DONE;
`endif
          end else begin
            state_next_s = DAT_HI;
          end
        end else begin
          state_next_s = DAT_LO;
        end
      end
`ifdef RISC16_MEM_CHKSUM_EN
      CHK: begin
        if (accept_s) begin
          if (sum8(sum_r, ld_data) == 8'h00) state_next_s = DONE;
          else                              state_next_s = ERR;
        end else begin
          state_next_s = CHK;
        end
      end
`endif
      DONE, ERR: begin
        if (ld_restart) begin
          state_next_s    = CNT_HI;
          word_cnt_next_s = 15'd0;
`ifdef RISC16_MEM_CHKSUM_EN
          sum_next_s      = 8'h00;
`endif
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = CNT_HI;
      end
    endcase
  end

  // State, loader datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= CNT_HI;
      count_r    <= 16'd0;
      word_cnt_r <= 15'd0;
      hi_byte_r  <= 8'h00;
      cpu_hold_r <= 1'b1;
      ld_done_r  <= 1'b0;
      ld_err_r   <= 1'b0;
      ld_ready_r <= 1'b1;
`ifdef RISC16_MEM_CHKSUM_EN
      sum_r      <= 8'h00;
`endif
    end else begin
      state_r    <= state_next_s;
      count_r    <= count_next_s;
      word_cnt_r <= word_cnt_next_s;
      hi_byte_r  <= hi_byte_next_s;
      cpu_hold_r <= (state_next_s != DONE);
      ld_done_r  <= (state_next_s == DONE);
      ld_err_r   <= (state_next_s == ERR);
      ld_ready_r <= (state_next_s != DONE) && (state_next_s != ERR);
`ifdef RISC16_MEM_CHKSUM_EN
      sum_r      <= sum_next_s;
`endif
    end
  end

  // Write port arbitration: loader first, core only once released from hold
  always_comb begin
    mem_we_s    = 2'b00;
    mem_widx_s  = d_addr[15:1];
    mem_wdata_s = d_dout;
    if (rst) begin
      mem_we_s = 2'b00;
    end else if ((state_r == DAT_LO) && accept_s) begin
      mem_we_s    = 2'b11;
      mem_widx_s  = word_cnt_r;
      mem_wdata_s = {hi_byte_r, ld_data};
    end else if (!cpu_hold_r) begin
      mem_we_s = d_we;
    end else begin
      mem_we_s = 2'b00;
    end
  end

  risc16_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .ra_idx (i_addr[15:1]),
    .ra_data(ra_data_s),
    .rb_idx (d_addr[15:1]),
    .rb_data(rb_data_s),
    .we     (mem_we_s),
    .w_idx  (mem_widx_s),
    .w_data (mem_wdata_s)
  );

  assign i_din    = (i_oe && !cpu_hold_r) ? ra_data_s : 16'h0000;
  assign d_din    = (d_oe && !cpu_hold_r) ? rb_data_s : 16'h0000;
  assign ld_ready = ld_ready_r;
  assign cpu_hold = cpu_hold_r;
  assign ld_done  = ld_done_r;
  assign ld_err   = ld_err_r;

endmodule
